// File: rtl/alu_sched.sv
// Two-requester round-robin scheduler around a shared ALU; multi-bit shifts are
// built by iterating the ALU's 1-bit shifter, one position per EXEC cycle.

module alu_functions #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] inp_a,
  input  logic [WIDTH-1:0] inp_b,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] sfl_out,
  output logic [WIDTH-1:0] sfr_out,
  output logic             cf,
  output logic             vf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  always_comb begin
    sum     = {1'b0, inp_a} + {1'b0, inp_b};
    // Subtract as a + ~b + 1 so carry reads as "no borrow".
    diff    = {1'b0, inp_a} + {1'b0, ~inp_b} + {{WIDTH{1'b0}}, 1'b1};
    sfl_out = {inp_a[WIDTH-2:0], 1'b0};
    sfr_out = {1'b0, inp_a[WIDTH-1:1]};
    alu_out = inp_a;
    cf      = 1'b0;
    vf      = 1'b0;
    unique case (op)
      3'd0: begin
        alu_out = sum[WIDTH-1:0];
        cf      = sum[WIDTH];
        vf      = (inp_a[WIDTH-1] == inp_b[WIDTH-1]) && (sum[WIDTH-1] != inp_a[WIDTH-1]);
      end
      3'd1: begin
        alu_out = diff[WIDTH-1:0];
        cf      = diff[WIDTH];
        vf      = (inp_a[WIDTH-1] != inp_b[WIDTH-1]) && (diff[WIDTH-1] != inp_a[WIDTH-1]);
      end
      3'd2: alu_out = inp_a & inp_b;
      3'd3: alu_out = inp_a | inp_b;
      3'd4: alu_out = inp_a ^ inp_b;
      3'd5: begin
        alu_out = sfl_out;
        cf      = inp_a[WIDTH-1];
      end
      3'd6: begin
        alu_out = sfr_out;
        cf      = inp_a[0];
      end
      3'd7: alu_out = inp_a;
    endcase
  end

endmodule

module alu_sched #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [2:0]       req_op0,
  input  logic [2:0]       req_op1,
  input  logic [WIDTH-1:0] inp_a0,
  input  logic [WIDTH-1:0] inp_b0,
  input  logic [WIDTH-1:0] inp_a1,
  input  logic [WIDTH-1:0] inp_b1,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_cf,
  output logic             rsp_nf,
  output logic             rsp_zf,
  output logic             rsp_vf,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e           state_q, state_d;
  logic             last_id_q, last_id_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] w_q, w_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             rid_q, rid_d;
  logic             cf_q, cf_d, nf_q, nf_d, zf_q, zf_d, vf_q, vf_d;

  logic [WIDTH-1:0] alu_out, sfl_out, sfr_out, shift_out, result;
  logic             alu_cf, alu_vf, grant, is_shift, done;

  alu_functions #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op     (op_q),
    .inp_a  (w_q),
    .inp_b  (b_q),
    .alu_out(alu_out),
    .sfl_out(sfl_out),
    .sfr_out(sfr_out),
    .cf     (alu_cf),
    .vf     (alu_vf)
  );

  always_comb begin
    state_d   = state_q;
    last_id_d = last_id_q;
    op_d      = op_q;
    w_d       = w_q;
    b_d       = b_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    rid_d     = rid_q;
    cf_d      = cf_q;
    nf_d      = nf_q;
    zf_d      = zf_q;
    vf_d      = vf_q;
    req_ready = 2'b00;

    grant     = (req_valid == 2'b11) ? ~last_id_q : req_valid[1];
    is_shift  = (op_q == 3'd5) || (op_q == 3'd6);
    shift_out = (op_q == 3'd5) ? sfl_out : sfr_out;
    // A zero-length shift finishes on its single EXEC cycle with the unshifted operand.
    result    = !is_shift ? alu_out : ((cnt_q == '0) ? w_q : shift_out);
    done      = !is_shift || (cnt_q[SHW-1:1] == '0);

    unique case (state_q)
      StIdle: begin
        if (rst_n && (req_valid != 2'b00)) begin
          req_ready = grant ? 2'b10 : 2'b01;
          state_d   = StExec;
          op_d      = grant ? req_op1 : req_op0;
          w_d       = grant ? inp_a1 : inp_a0;
          b_d       = grant ? inp_b1 : inp_b0;
          cnt_d     = grant ? inp_b1[SHW-1:0] : inp_b0[SHW-1:0];
          id_d      = grant;
        end
      end
      StExec: begin
        if (done) begin
          state_d = StResp;
          data_d  = result;
          rid_d   = id_q;
          cf_d    = alu_cf;
          vf_d    = alu_vf;
          zf_d    = (result == '0);
          nf_d    = result[WIDTH-1];
        end else begin
          w_d   = shift_out;
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d   = StIdle;
          last_id_d = rid_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_id_q <= 1'b1;
      op_q      <= '0;
      w_q       <= '0;
      b_q       <= '0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      data_q    <= '0;
      rid_q     <= 1'b0;
      cf_q      <= 1'b0;
      nf_q      <= 1'b0;
      zf_q      <= 1'b0;
      vf_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_id_q <= last_id_d;
      op_q      <= op_d;
      w_q       <= w_d;
      b_q       <= b_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      rid_q     <= rid_d;
      cf_q      <= cf_d;
      nf_q      <= nf_d;
      zf_q      <= zf_d;
      vf_q      <= vf_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign busy      = (state_q != StIdle);
  assign rsp_id    = rid_q;
  assign rsp_data  = data_q;
  assign rsp_cf    = cf_q;
  assign rsp_nf    = nf_q;
  assign rsp_zf    = zf_q;
  assign rsp_vf    = vf_q;

endmodule

// File: tb/tb_alu_sched.sv
// Directed bench for alu_sched: arbitration, latency, flags, backpressure and reset.

module tb_alu_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [2:0]  req_op0 = 3'd0, req_op1 = 3'd0;
  logic [31:0] inp_a0 = '0, inp_b0 = '0, inp_a1 = '0, inp_b1 = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_cf, rsp_nf, rsp_zf, rsp_vf, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_sched #(
    .WIDTH(32),
    .SHW  (5)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op0  (req_op0),
    .req_op1  (req_op1),
    .inp_a0   (inp_a0),
    .inp_b0   (inp_b0),
    .inp_a1   (inp_a1),
    .inp_b1   (inp_b1),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .rsp_cf   (rsp_cf),
    .rsp_nf   (rsp_nf),
    .rsp_zf   (rsp_zf),
    .rsp_vf   (rsp_vf),
    .busy     (busy)
  );

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = 2'b00;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Raise a request on port p and drop it right after the accepting edge.
  task automatic send(input int p, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    bit ok = 0;
    @(negedge clk);
    if (p == 0) begin
      req_op0 = op; inp_a0 = a; inp_b0 = b;
    end else begin
      req_op1 = op; inp_a1 = a; inp_b1 = b;
    end
    req_valid[p] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (req_ready[p]) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL send_accept port %0d: req_ready=%b, required port bit high", p, req_ready);
    end
    @(posedge clk);
    #1 req_valid[p] = 1'b0;
  endtask

  // Counts rising edges from the accepting edge until rsp_valid is seen.
  task automatic wait_rsp(output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!rsp_valid && cyc < 200);
    if (!rsp_valid) begin
      n_tests++; n_fail++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, cyc);
    end
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 2'b11;
    #3;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid_busy: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data_id: data=%h id=%b, required 0 0", rsp_data, rsp_id);
    end
    n_tests++;
    if ({rsp_cf, rsp_nf, rsp_zf, rsp_vf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000", {rsp_cf, rsp_nf, rsp_zf, rsp_vf});
    end
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_req_ready: got %b, required 00", req_ready);
    end
    apply_reset();
  endtask

  task automatic test_add_carry();
    int cyc;
    apply_reset();
    send(0, 3'd0, 32'hFFFF_FFFF, 32'h1);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 1) begin
      n_fail++; $display("FAIL add_latency: got %0d, required 1", cyc);
    end
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL add_data_id: data=%h id=%b, required 0 0", rsp_data, rsp_id);
    end
    n_tests++;
    if ({rsp_cf, rsp_nf, rsp_zf, rsp_vf} !== 4'b1010) begin
      n_fail++;
      $display("FAIL add_flags cf,nf,zf,vf: got %b, required 1010",
               {rsp_cf, rsp_nf, rsp_zf, rsp_vf});
    end
    finish_rsp();
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL add_release: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy);
    end
    send(1, 3'd0, 32'h7FFF_FFFF, 32'h1);
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'h8000_0000 || rsp_id !== 1'b1 ||
        {rsp_cf, rsp_nf, rsp_zf, rsp_vf} !== 4'b0101) begin
      n_fail++;
      $display("FAIL add_overflow: data=%h id=%b flags=%b, required 80000000 1 0101",
               rsp_data, rsp_id, {rsp_cf, rsp_nf, rsp_zf, rsp_vf});
    end
    finish_rsp();
  endtask

  task automatic test_round_robin();
    int cyc, ep, idx0, idx1;
    logic [31:0] expd;
    apply_reset();
    idx0 = 0; idx1 = 0;
    req_op0 = 3'd4; inp_a0 = 32'h1000_0001; inp_b0 = 32'h0F0F_0F0F;
    req_op1 = 3'd4; inp_a1 = 32'h2000_0001; inp_b1 = 32'h00FF_00FF;
    req_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      ep = t % 2;
      #1;
      n_tests++;
      if (req_ready !== ((ep == 1) ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant turn %0d: req_ready=%b, required port %0d", t, req_ready, ep);
      end
      @(posedge clk);
      #1;
      if (ep == 0) begin
        expd = (32'h1000_0001 + idx0) ^ 32'h0F0F_0F0F;
        idx0++;
        if (idx0 == 2) req_valid[0] = 1'b0;
        else inp_a0 = 32'h1000_0001 + idx0;
      end else begin
        expd = (32'h2000_0001 + idx1) ^ 32'h00FF_00FF;
        idx1++;
        if (idx1 == 2) req_valid[1] = 1'b0;
        else inp_a1 = 32'h2000_0001 + idx1;
      end
      wait_rsp(cyc);
      n_tests++;
      if (rsp_id !== ep[0] || rsp_data !== expd || cyc !== 1) begin
        n_fail++;
        $display("FAIL rr_rsp turn %0d: id=%b data=%h lat=%0d, required %0d %h 1",
                 t, rsp_id, rsp_data, cyc, ep, expd);
      end
      n_tests++;
      if (req_ready !== 2'b00) begin
        n_fail++; $display("FAIL rr_ready_in_resp turn %0d: got %b, required 00", t, req_ready);
      end
      finish_rsp();
    end
  endtask

  task automatic test_shift();
    int cyc;
    send(0, 3'd5, 32'h1, 32'd31);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 31 || rsp_data !== 32'h8000_0000 || rsp_nf !== 1'b1 || rsp_zf !== 1'b0) begin
      n_fail++;
      $display("FAIL shl31: lat=%0d data=%h nf=%b zf=%b, required 31 80000000 1 0",
               cyc, rsp_data, rsp_nf, rsp_zf);
    end
    finish_rsp();
    send(1, 3'd6, 32'h8000_0000, 32'd0);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 1 || rsp_data !== 32'h8000_0000) begin
      n_fail++; $display("FAIL shr0: lat=%0d data=%h, required 1 80000000", cyc, rsp_data);
    end
    finish_rsp();
    // Only the low five bits of b count: 0xFFFFFFE4 means four positions.
    send(0, 3'd6, 32'hF000_0000, 32'hFFFF_FFE4);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 4 || rsp_data !== 32'h0F00_0000 || rsp_nf !== 1'b0) begin
      n_fail++;
      $display("FAIL shr4: lat=%0d data=%h nf=%b, required 4 0f000000 0", cyc, rsp_data, rsp_nf);
    end
    finish_rsp();
    send(1, 3'd5, 32'hFFFF_FFFF, 32'd32);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 1 || rsp_data !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL shl_wrap0: lat=%0d data=%h, required 1 ffffffff", cyc, rsp_data);
    end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int cyc;
    bit bad_hold = 0;
    send(1, 3'd0, 32'd3, 32'd4);
    req_op0 = 3'd2; inp_a0 = 32'h0000_F0F0; inp_b0 = 32'h0000_FF00;
    req_valid[0] = 1'b1;
    wait_rsp(cyc);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd7 || rsp_id !== 1'b1 ||
          {rsp_cf, rsp_nf, rsp_zf, rsp_vf} !== 4'b0000 || req_ready !== 2'b00) bad_hold = 1;
    end
    n_tests++;
    if (bad_hold) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b data=%h id=%b ready=%b, required 1 00000007 1 00",
               rsp_valid, rsp_data, rsp_id, req_ready);
    end
    rsp_ready = 1'b1;
    #1;
    n_tests++;
    if (req_ready !== 2'b00) begin
      n_fail++; $display("FAIL bp_ready_indep: got %b, required 00", req_ready);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    n_tests++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL bp_complete: valid=%b busy=%b ready=%b, required 0 0 01",
               rsp_valid, busy, req_ready);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'h0000_F000 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL bp_pending: data=%h id=%b, required 0000f000 0", rsp_data, rsp_id);
    end
    finish_rsp();
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    bit seen = 0;
    send(0, 3'd7, 32'h8000_0001, 32'h0);
    wait_rsp(cyc);
    finish_rsp();
    send(0, 3'd5, 32'h3, 32'd20);
    repeat (9) @(posedge clk);
    #2;
    req_op0 = 3'd0; inp_a0 = 32'd10; inp_b0 = 32'd20;
    req_op1 = 3'd0; inp_a1 = 32'd1;  inp_b1 = 32'd1;
    rst_n = 1'b0;
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL midrst_ctrl: busy=%b valid=%b ready=%b, required 0 0 00",
               busy, rsp_valid, req_ready);
    end
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_id !== 1'b0 || {rsp_cf, rsp_nf, rsp_zf, rsp_vf} !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_rsp: data=%h id=%b flags=%b, required 0 0 0000",
               rsp_data, rsp_id, {rsp_cf, rsp_nf, rsp_zf, rsp_vf});
    end
    req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    n_tests++;
    if (seen) begin
      n_fail++; $display("FAIL midrst_no_rsp: rsp_valid/busy seen high, required 0");
    end
    req_valid = 2'b11;
    #1;
    n_tests++;
    if (req_ready !== 2'b01) begin
      n_fail++; $display("FAIL midrst_tie: got %b, required 01", req_ready);
    end
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'd30 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL midrst_first: data=%h id=%b, required 0000001e 0", rsp_data, rsp_id);
    end
    finish_rsp();
    #1;
    n_tests++;
    if (req_ready !== 2'b10) begin
      n_fail++; $display("FAIL midrst_second_grant: got %b, required 10", req_ready);
    end
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'd2 || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL midrst_second: data=%h id=%b, required 00000002 1", rsp_data, rsp_id);
    end
    finish_rsp();
  endtask

  task automatic test_sub_pass();
    int cyc;
    send(0, 3'd1, 32'd5, 32'd5);
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'h0 || rsp_zf !== 1'b1 || rsp_nf !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_eq: data=%h zf=%b nf=%b, required 0 1 0", rsp_data, rsp_zf, rsp_nf);
    end
    finish_rsp();
    send(1, 3'd7, 32'h7FFF_FFFF, 32'h1234_5678);
    wait_rsp(cyc);
    n_tests++;
    if (cyc !== 1 || rsp_data !== 32'h7FFF_FFFF || rsp_zf !== 1'b0 || rsp_nf !== 1'b0) begin
      n_fail++;
      $display("FAIL pass: lat=%0d data=%h zf=%b nf=%b, required 1 7fffffff 0 0",
               cyc, rsp_data, rsp_zf, rsp_nf);
    end
    finish_rsp();
    send(0, 3'd3, 32'h0000_00F0, 32'h0000_000F);
    wait_rsp(cyc);
    n_tests++;
    if (rsp_data !== 32'h0000_00FF) begin
      n_fail++; $display("FAIL or: data=%h, required 000000ff", rsp_data);
    end
    finish_rsp();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_carry();
    test_round_robin();
    test_shift();
    test_backpressure();
    test_reset_mid_op();
    test_sub_pass();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
